// File: rtl/p_row_bank.sv
// DEPTH x WIDTH settled-block grid with row write, collapse, wipe, full-row
// detection, registered read and a saturating cleared-line counter.
module p_row_bank #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 20,
  parameter int unsigned AW    = 5,
  parameter int unsigned CW    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic [DEPTH-1:0] full_mask,
  output logic             any_full,
  output logic [CW-1:0]    lines,
  output logic             err
);

  localparam logic [1:0] OP_NOP      = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_COLLAPSE = 2'b10;
  localparam logic [1:0] OP_WIPE     = 2'b11;

  logic [WIDTH-1:0] rows     [DEPTH];
  logic [WIDTH-1:0] rows_nxt [DEPTH];
  logic [WIDTH-1:0] rd_c;
  logic             addr_bad_c;
  logic             raddr_bad_c;
  logic             op_addr_c;

  // Compare one bit wider so DEPTH == 2**AW is representable.
  assign addr_bad_c  = {1'b0, addr}  >= (AW+1)'(DEPTH);
  assign raddr_bad_c = {1'b0, raddr} >= (AW+1)'(DEPTH);
  assign op_addr_c   = (op == OP_WRITE) || (op == OP_COLLAPSE);

  // Next storage contents for the requested operation.
  always_comb begin
    for (int r = 0; r < int'(DEPTH); r++) rows_nxt[r] = rows[r];
    case (op)
      OP_WRITE: begin
        if (!addr_bad_c) begin
          for (int r = 0; r < int'(DEPTH); r++)
            if (addr == AW'(r)) rows_nxt[r] = wdata;
        end
      end
      OP_COLLAPSE: begin
        if (!addr_bad_c) begin
          for (int r = 1; r < int'(DEPTH); r++)
            if ({1'b0, addr} >= (AW+1)'(r)) rows_nxt[r] = rows[r-1];
          rows_nxt[0] = '0;
        end
      end
      OP_WIPE: begin
        for (int r = 0; r < int'(DEPTH); r++) rows_nxt[r] = '0;
      end
      default: ;
    endcase
  end

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    rd_c = '0;
    for (int r = 0; r < int'(DEPTH); r++)
      if (raddr == AW'(r)) rd_c = rows[r];
  end

  always_comb begin
    for (int r = 0; r < int'(DEPTH); r++) full_mask[r] = &rows[r];
  end
  assign any_full = |full_mask;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int r = 0; r < int'(DEPTH); r++) rows[r] <= '0;
      rdata <= '0;
      lines <= '0;
      err   <= 1'b0;
    end else if (en) begin
      for (int r = 0; r < int'(DEPTH); r++) rows[r] <= rows_nxt[r];
      rdata <= raddr_bad_c ? '0 : rd_c;
      err   <= (op_addr_c && addr_bad_c) || raddr_bad_c;
      // Counted per accepted collapse, regardless of row content.
      if (op == OP_COLLAPSE && !addr_bad_c && lines != {CW{1'b1}})
        lines <= lines + CW'(1);
    end else begin
      err <= 1'b0;
    end
  end

endmodule

// File: doc/p_row_bank.md
Name: p_row_bank

Overview:
- Parametrised successor to the single-bit enabled/clearable flop: a DEPTH-row by WIDTH-bit register bank, built from the same enable/async-clear flop behaviour.
- Adds row write, row collapse (delete a row; rows above shift down), synchronous wipe, full-row detection, registered read and a cleared-line counter.
- Sits between game control logic and the playfield renderer. Holds the settled-block grid.

Parameters:
- WIDTH, 10, bits per row (playfield columns).
- DEPTH, 20, number of rows; row 0 is top, row DEPTH-1 is bottom.
- AW, 5, address width; must satisfy 2^AW >= DEPTH.
- CW, 16, width of lines-cleared counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  asynchronous active-high reset.
- en  in  1  global enable; when low, no state changes except clr.
- op  in  2  operation: 00 NOP, 01 WRITE, 10 COLLAPSE, 11 WIPE.
- addr  in  AW  target row for WRITE/COLLAPSE.
- wdata  in  WIDTH  row data for WRITE.
- raddr  in  AW  read row address.
- rdata  out  WIDTH  registered read data.
- full_mask  out  DEPTH  bit r = 1 when row r is all ones (combinational from storage).
- any_full  out  1  OR of full_mask.
- lines  out  CW  saturating count of completed COLLAPSE ops.
- err  out  1  one-cycle pulse on an out-of-range addr or raddr.

Behaviour:
- Reset: clr=1 asynchronously forces every row, rdata, lines and err to 0. Power-up initial value is also all 0. clr dominates clk/en. Deassertion mid-sequence resumes from all-zero state; no pending op survives.
- en=0: rows, rdata, lines hold; err driven 0.
- NOP (en=1): storage unchanged.
- WRITE: row[addr] <= wdata at posedge. Visible on rdata/full_mask from the next cycle.
- COLLAPSE addr=k:
  - For r in 1..k: row[r] <= row[r-1].
  - row[0] <= 0.
  - Rows k+1..DEPTH-1 unchanged.
  - lines <= lines+1, saturating at 2^CW-1, no wrap.
  - k=0 just zeroes row 0.
  - Collapse is performed whether or not row k is full; counting is by op, not by content.
- WIPE: all rows <= 0 in one cycle. lines unchanged. addr/wdata ignored.
- Range check: addr >= DEPTH with op WRITE or COLLAPSE:
  - Op is dropped; no storage change, lines unchanged.
  - err=1 next cycle.
  - raddr >= DEPTH: rdata <= 0 and err=1 next cycle. Both errors in one cycle give a single err pulse.
- Read: rdata <= row[raddr] each enabled posedge, latency 1. Same-cycle WRITE/COLLAPSE/WIPE: rdata returns the pre-update contents (read-before-write).
- full_mask/any_full: purely combinational from current storage, no latency beyond the storage flops. WIDTH=1 and DEPTH=1 must be legal. With DEPTH=1, COLLAPSE equals clearing row 0.
- Single op per cycle; no busy/stall.

Test Plan:
- Reset: pulse clr mid-cycle after writes -> rows, rdata, lines, err all 0 immediately, without a clock edge; full_mask=0.
- Write/read: WRITE addr=19 wdata=0x3FF, then raddr=19 -> rdata=0x3FF one cycle later; full_mask[19]=1, any_full=1. Same-cycle write+read of row 5 returns the old value 0x000.
- Collapse: rows 17=0x001, 18=0x002, 19=0x3FF; COLLAPSE addr=19 -> row19=0x002, row18=0x001, row17=0x000, row0=0, lines=1, any_full=0.
- Collapse top: row0=0x155, COLLAPSE addr=0 -> row0=0, other rows unchanged, lines increments.
- Enable/error: en=0 with WRITE -> no change, err=0. en=1 WRITE addr=25 -> no change, err pulses exactly 1 cycle. raddr=31 -> rdata=0, err=1.
- Saturation and wipe: CW=2, five COLLAPSE ops -> lines=3 (no wrap). WIPE -> all rows 0, lines stays 3.
